cache_axi_arbiter: RTL and testbench
====================================

CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the system clock; all logic SHALL be sampled on its rising edge.
REQ-002 The module SHALL have the port resetn, input, 1 bit, the reset: synchronous, active-low.
REQ-003 The module SHALL have the ports i_rd_req in 1, i_rd_addr in 32, i_rd_rdy out 1, i_ret_valid out 1 and i_ret_data out 128, forming the ICache refill port.
REQ-004 The module SHALL have the ports d_rd_req in 1, d_rd_addr in 32, d_rd_rdy out 1, d_ret_valid out 1 and d_ret_data out 128, forming the DCache refill port.
REQ-005 The module SHALL have the AXI read-address ports arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3 and arburst out 2.
REQ-006 The module SHALL have the AXI read-data ports rvalid in 1, rready out 1, rdata in 32, rid in 4 and rlast in 1.
REQ-007 The module SHALL have the parameter LINE_BEATS, default 4, giving the number of 32-bit beats per cache line.

Function
REQ-008 The FSM SHALL have exactly the states IDLE, AR, R and RET.
REQ-009 In IDLE with exactly one rd_req high, the FSM SHALL grant that requester.
REQ-010 In IDLE with both rd_req high, the FSM SHALL grant the requester not granted last (round-robin), using the last_grant register.
REQ-011 On reset, last_grant SHALL equal DCache, so ICache wins the first tie.
REQ-012 The rd_rdy of the granted requester SHALL be high combinationally in the grant cycle only; rd_rdy SHALL be 0 in every other state.
REQ-013 In the grant cycle, the FSM SHALL latch {rd_addr[31:4],4'b0} and the grant, then move to AR.
REQ-014 In AR, the module SHALL drive arvalid=1, araddr=latched address, arlen=LINE_BEATS-1, arsize=3'b010, arburst=2'b01 and arid=0 (ICache) or 1 (DCache).
REQ-015 araddr, arid, arlen, arsize and arburst SHALL stay stable while arvalid=1 and arready=0.
REQ-016 On arvalid&&arready, the FSM SHALL move to R and clear the beat counter.
REQ-017 In R, the module SHALL drive rready=1.
REQ-018 Each rvalid beat in R SHALL write rdata into line buffer word [cnt], bits cnt*32+31:cnt*32, then increment cnt.
REQ-019 The beat counter SHALL saturate at LINE_BEATS-1; extra beats SHALL overwrite the last word.
REQ-020 On rvalid&&rlast in R, the FSM SHALL store the beat and move to RET; rlast arriving early SHALL leave unreceived words at their old contents.
REQ-021 In RET, the granted port SHALL see ret_valid=1 for exactly one cycle with ret_data=line buffer, while the other port's ret_valid stays 0; then the FSM SHALL move to IDLE and update last_grant.
REQ-022 ret_data of both ports SHALL always reflect the line buffer; it is meaningful only while ret_valid=1.
REQ-023 rd_req inputs SHALL be ignored outside IDLE; a requester SHALL hold rd_req until it sees rd_rdy.
REQ-024 rid SHALL be ignored (single outstanding transaction).
REQ-025 With arready and rvalid always 1, the latency from the grant cycle (cycle 0) SHALL be: arvalid at cycle 1, beats at cycles 2-5, ret_valid at cycle 6, and the next grant possible at cycle 7.

Reset
REQ-026 When resetn=0 at a clock edge, the module SHALL go to IDLE and clear cnt, all valid/rdy/rready outputs and the line buffer to 0, and set last_grant=DCache.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no ret_valid; the downstream AXI slave SHALL be reset together with this module.

Verification
REQ-028 ICache-only path: i_rd_req=1, i_rd_addr=0x1FC0_0014, slave ready; expect i_rd_rdy at cycle 0, araddr=0x1FC0_0010 with arid=0, and after beats 0x11,0x22,0x33,0x44, i_ret_data=0x00000044_00000033_00000022_00000011 at cycle 6 with d_ret_valid=0.
REQ-029 Tie after reset: both requests at cycle 0; expect ICache granted first, DCache granted at the next IDLE (arid=1), and with both requests held, grants alternate I,D,I,D.
REQ-030 arready backpressure: hold arready=0 for 5 cycles; expect arvalid and araddr stable throughout and a single AR handshake.
REQ-031 rvalid gaps: send beats with 2 idle cycles between each; expect a correct line and exactly one ret_valid pulse.
REQ-032 Reset during R after 2 beats; expect IDLE next cycle, all outputs 0, and no ret_valid.
REQ-033 Early rlast on beat 1; expect RET next cycle, words 0-1 new and words 2-3 old.

Source files
------------

// File: rtl/cache_axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter_if
//   Bundles the two cache refill ports and the AXI read channels used by
//   cache_axi_arbiter.
//
//   ICache refill : i_rd_req, i_rd_addr -> ; <- i_rd_rdy, i_ret_valid, i_ret_data
//   DCache refill : d_rd_req, d_rd_addr -> ; <- d_rd_rdy, d_ret_valid, d_ret_data
//   AXI AR        : arvalid, araddr, arid, arlen, arsize, arburst ; <- arready
//   AXI R         : rready ; <- rvalid, rdata, rid, rlast
//
//   modport master : the arbiter side (AXI master, refill server)
//   modport slave  : the environment side (caches and AXI slave)
// ---------------------------------------------------------------------------
interface cache_axi_arbiter_if #(
  parameter int LINE_BEATS = 4
);
  // ICache refill port
  logic                     i_rd_req;
  logic [31:0]              i_rd_addr;
  logic                     i_rd_rdy;
  logic                     i_ret_valid;
  logic [LINE_BEATS*32-1:0] i_ret_data;

  // DCache refill port
  logic                     d_rd_req;
  logic [31:0]              d_rd_addr;
  logic                     d_rd_rdy;
  logic                     d_ret_valid;
  logic [LINE_BEATS*32-1:0] d_ret_data;

  // AXI read address channel
  logic                     arvalid;
  logic                     arready;
  logic [31:0]              araddr;
  logic [3:0]               arid;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;

  // AXI read data channel
  logic                     rvalid;
  logic                     rready;
  logic [31:0]              rdata;
  logic [3:0]               rid;
  logic                     rlast;

  modport master (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    input  arready, rvalid, rdata, rid, rlast,
    output i_rd_rdy, i_ret_valid, i_ret_data,
    output d_rd_rdy, d_ret_valid, d_ret_data,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    output arready, rvalid, rdata, rid, rlast,
    input  i_rd_rdy, i_ret_valid, i_ret_data,
    input  d_rd_rdy, d_ret_valid, d_ret_data,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter
//   Shares one AXI read port between the ICache and DCache refill ports.
//   One line refill is in flight at a time: a requester is granted in IDLE
//   (round-robin on ties), one INCR burst of LINE_BEATS 32-bit beats is
//   issued, the beats are collected into a line buffer, and the full line
//   is returned to the granted cache with a one-cycle ret_valid pulse.
//
//   Ports:
//     clk    - system clock, rising edge
//     resetn - synchronous, active-low reset
//     bus    - cache_axi_arbiter_if.master (refill ports + AXI AR/R)
// ---------------------------------------------------------------------------
module cache_axi_arbiter #(
  parameter int LINE_BEATS = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  cache_axi_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RET  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int               CNT_W   = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_BEATS - 1);

  state_t           state_q, state_d;
  grant_t           grant_q, grant_d;
  grant_t           last_grant_q;
  logic [31:4]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      line_q [LINE_BEATS];

  logic             pick_d;
  logic [31:0]      sel_addr;
  logic [LINE_BEATS*32-1:0] line_flat;

  // Transaction id and the sub-line offset bits carry no information here:
  // only one burst is ever outstanding and refills are line aligned.
  logic unused_bits;
  assign unused_bits = ^{bus.rid, bus.i_rd_addr[3:0], bus.d_rd_addr[3:0]};

  // DCache wins when it asks alone, or on a tie when ICache was served last.
  assign pick_d   = bus.d_rd_req && (!bus.i_rd_req || (last_grant_q == GNT_I));
  assign sel_addr = pick_d ? bus.d_rd_addr : bus.i_rd_addr;

  // AR payload comes straight from registers, so it cannot change while
  // arvalid waits for arready.
  assign bus.araddr  = {addr_q, 4'b0000};
  assign bus.arid    = {3'b000, (grant_q == GNT_D)};
  assign bus.arlen   = 8'(LINE_BEATS - 1);
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    bus.i_rd_rdy    = 1'b0;
    bus.d_rd_rdy    = 1'b0;
    bus.arvalid     = 1'b0;
    bus.rready      = 1'b0;
    bus.i_ret_valid = 1'b0;
    bus.d_ret_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_rd_req || bus.d_rd_req) begin
          grant_d      = pick_d ? GNT_D : GNT_I;
          bus.i_rd_rdy = !pick_d;
          bus.d_rd_rdy = pick_d;
          state_d      = AR;
        end
      end
      AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_d = R;
      end
      R: begin
        bus.rready = 1'b1;
        if (bus.rvalid && bus.rlast) state_d = RET;
      end
      RET: begin
        bus.i_ret_valid = (grant_q == GNT_I);
        bus.d_ret_valid = (grant_q == GNT_D);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Both ports see the line buffer at all times; ret_valid qualifies it.
  always_comb begin
    line_flat = '0;
    for (int w = 0; w < LINE_BEATS; w++) begin
      line_flat[w*32 +: 32] = line_q[w];
    end
  end

  assign bus.i_ret_data = line_flat;
  assign bus.d_ret_data = line_flat;

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
      cnt_q        <= '0;
      // NOTE: the line buffer is explicitly cleared on reset because its
      // contents are visible on ret_data and survive short (early rlast)
      // bursts; this rules out mapping it onto a reset-less RAM.
      for (int w = 0; w < LINE_BEATS; w++) begin
        line_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;

      if ((state_q == IDLE) && (state_d == AR)) begin
        addr_q <= sel_addr[31:4];
      end

      if ((state_q == AR) && bus.arready) begin
        cnt_q <= '0;
      end

      // Beats beyond the line length keep landing in the last word.
      if ((state_q == R) && bus.rvalid) begin
        line_q[cnt_q] <= bus.rdata;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == RET) begin
        last_grant_q <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter
//   Self-checking bench for cache_axi_arbiter. The bench plays both caches
//   and the AXI slave, and predicts each refill at transaction level:
//   which cache is served (round-robin rule), the AR payload, and the line
//   returned (words written in beat order, last word absorbing overflow).
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;

  localparam int LB = 4;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  cache_axi_arbiter_if #(.LINE_BEATS(LB)) bus ();

  cache_axi_arbiter #(.LINE_BEATS(LB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit          last_was_d;
  logic [31:0] mline [LB];
  bit          pend_i, pend_d;
  logic [31:0] addr_i, addr_d;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LB*32-1:0] model_line();
    logic [LB*32-1:0] v;
    v = '0;
    for (int w = 0; w < LB; w++) v[w*32 +: 32] = mline[w];
    return v;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    bus.i_rd_req  = pend_i;
    bus.d_rd_req  = pend_d;
    bus.i_rd_addr = addr_i;
    bus.d_rd_addr = addr_d;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_i_rdy"},  bus.i_rd_rdy,    0);
    check({tag, "_d_rdy"},  bus.d_rd_rdy,    0);
    check({tag, "_arvld"},  bus.arvalid,     0);
    check({tag, "_rready"}, bus.rready,      0);
    check({tag, "_i_ret"},  bus.i_ret_valid, 0);
    check({tag, "_d_ret"},  bus.d_ret_valid, 0);
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    pend_i       = 1'b0;
    pend_d       = 1'b0;
    drive_reqs();
    bus.arready  = 1'b0;
    bus.rvalid   = 1'b0;
    bus.rlast    = 1'b0;
    tick();
    resetn       = 1'b1;
    last_was_d   = 1'b1;
    for (int w = 0; w < LB; w++) mline[w] = '0;
    #1;
    check_all_quiet("rst");
    check("rst_line", bus.i_ret_data, 0);
  endtask

  // One refill. abort_after >= 0 asserts reset in the R cycle after that
  // many beats and expects the transaction to vanish.
  task automatic run_txn(input int ar_wait, input int gap, input int nbeats,
                         input bit fixed, input int abort_after);
    bit          gnt_d;
    logic [31:0] a, data;
    gnt_d = pend_d && (!pend_i || !last_was_d);
    a     = (gnt_d ? addr_d : addr_i) & 32'hFFFF_FFF0;

    // Grant cycle
    drive_reqs();
    #1;
    check("gnt_i_rdy", bus.i_rd_rdy, !gnt_d);
    check("gnt_d_rdy", bus.d_rd_rdy, gnt_d);
    check("gnt_arvld", bus.arvalid, 0);
    check("gnt_i_ret", bus.i_ret_valid, 0);
    check("gnt_d_ret", bus.d_ret_valid, 0);
    tick();
    if (gnt_d) pend_d = 1'b0; else pend_i = 1'b0;
    drive_reqs();

    // Address phase, possibly stalled
    for (int c = 0; c <= ar_wait; c++) begin
      bus.arready = (c == ar_wait);
      #1;
      check("ar_valid", bus.arvalid, 1);
      check("ar_addr",  bus.araddr,  a);
      check("ar_id",    bus.arid,    {3'b000, gnt_d});
      check("ar_len",   bus.arlen,   LB - 1);
      check("ar_size",  bus.arsize,  3'b010);
      check("ar_burst", bus.arburst, 2'b01);
      check("ar_rdy_lo", bus.i_rd_rdy | bus.d_rd_rdy, 0);
      tick();
    end
    bus.arready = 1'b0;

    // Data phase
    for (int k = 0; k < nbeats; k++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        check("r_gap_rready", bus.rready, 1);
        check("r_gap_ret", bus.i_ret_valid | bus.d_ret_valid, 0);
        tick();
      end
      if (k == abort_after) begin
        do_reset();
        for (int c = 0; c < 3; c++) begin
          tick();
          check_all_quiet("post_abort");
        end
        return;
      end
      data = fixed ? 32'h11 * (k + 1) : $urandom;
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rid    = 4'($urandom_range(0, 15));
      bus.rlast  = (k == nbeats - 1);
      #1;
      check("r_rready", bus.rready, 1);
      check("r_arvld",  bus.arvalid, 0);
      check("r_ret", bus.i_ret_valid | bus.d_ret_valid, 0);
      mline[(k < LB) ? k : LB - 1] = data;
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
    end

    // Return cycle
    #1;
    check("ret_i_valid", bus.i_ret_valid, !gnt_d);
    check("ret_d_valid", bus.d_ret_valid, gnt_d);
    check("ret_i_data",  bus.i_ret_data, model_line());
    check("ret_d_data",  bus.d_ret_data, model_line());
    check("ret_rready",  bus.rready, 0);
    last_was_d = gnt_d;
    tick();
  endtask

  initial begin
    resetn      = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rdata   = '0;
    bus.rid     = '0;
    addr_i      = '0;
    addr_d      = '0;
    pend_i      = 1'b0;
    pend_d      = 1'b0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ICache-only refill, full-speed slave; latency is implied by the
    // cycle-by-cycle checks in run_txn.
    pend_i = 1'b1;
    addr_i = 32'h1FC0_0014;
    run_txn(0, 0, 4, 1'b1, -1);
    check("fixed_line", bus.i_ret_data, 128'h00000044_00000033_00000022_00000011);
    check("fixed_quiet", bus.i_ret_valid | bus.d_ret_valid, 0);

    // Tie after reset, both requests held: I, D, I, D.
    do_reset();
    addr_i = 32'h0000_1234;
    addr_d = 32'h8000_5678;
    pend_i = 1'b1; pend_d = 1'b1;
    run_txn(0, 0, 4, 1'b0, -1);
    check("tie_1st_served_i", {31'b0, last_was_d}, 0);
    pend_i = 1'b1;
    run_txn(0, 0, 4, 1'b0, -1);
    check("tie_2nd_served_d", {31'b0, last_was_d}, 1);
    pend_d = 1'b1;
    run_txn(0, 0, 4, 1'b0, -1);
    pend_i = 1'b1;
    run_txn(0, 0, 4, 1'b0, -1);

    // arready backpressure
    pend_i = 1'b0;
    pend_d = 1'b1; addr_d = 32'h2000_00F8;
    run_txn(5, 0, 4, 1'b0, -1);

    // rvalid gaps
    pend_i = 1'b1; addr_i = 32'h3000_0040;
    run_txn(0, 2, 4, 1'b0, -1);

    // Early rlast: words 2-3 keep the previous line's values.
    pend_d = 1'b1; addr_d = 32'h4000_0000;
    run_txn(0, 0, 2, 1'b0, -1);

    // Overlong burst: extra beats overwrite the last word.
    pend_i = 1'b1; addr_i = 32'h5000_0010;
    run_txn(0, 0, 6, 1'b0, -1);

    // Reset in R after two beats.
    pend_d = 1'b1; addr_d = 32'h6000_0020;
    run_txn(0, 0, 4, 1'b0, 2);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1'b1; addr_i = $urandom;
      end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1'b1; addr_d = $urandom;
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1'b1; addr_i = $urandom;
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(1, 6), 1'b0, -1);
    end

    pend_i = 1'b0; pend_d = 1'b0;
    drive_reqs();
    #1;
    check_all_quiet("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
